// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_e            : access FSM encoding (IDLE / WAIT / DONE)
//   DATA_BASE_DEFAULT  : byte offset of the data segment within the ALU address space
//   MEM_ADDR_W_DEFAULT : word-address width presented to data memory
//   WB_REG_W           : MEM/WB register width {wb, memRead, aluResult, memoryData, destination}
package memory_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DATA_BASE_DEFAULT  = 1024;
    localparam int MEM_ADDR_W_DEFAULT = 16;
    localparam int WB_REG_W           = 1 * 2 + 32 * 2 + 4;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
//   memReq   : request, held high until memAck
//   memWe    : 1 = write, 0 = read; valid while memReq
//   memAddr  : word address; valid while memReq
//   memWdata : store data; valid while memReq
//   memAck   : single-cycle completion pulse from memory
//   memRdata : load data; valid in the memAck cycle
interface memory_stage_if #(
    parameter int MEM_ADDR_W = memory_stage_pkg::MEM_ADDR_W_DEFAULT
) ();
    logic                  memReq;
    logic                  memWe;
    logic [MEM_ADDR_W-1:0] memAddr;
    logic [31:0]           memWdata;
    logic                  memAck;
    logic [31:0]           memRdata;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memAck, memRdata
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memAck, memRdata
    );
endinterface

// File: rtl/memory_stage_reg.sv
// Generic load-enabled register used as the MEM/WB pipeline register.
//   clk  : clock
//   rst  : asynchronous active-low reset, clears the register
//   ld_i : load enable
//   d_i  : next value
//   q_o  : registered value
module memory_stage_reg #(
    parameter int WIDTH = 70
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_o <= '0;
        end else if (ld_i) begin
            q_o <= d_i;
        end
    end
endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues loads/stores on a variable-latency req/ack data memory,
// freezes the upstream pipeline while an access is outstanding and registers
// the MEM/WB outputs (bubble while frozen).
//   clk, rst (async active-low)
//   writebackEnabledIn/memoryReadEnabledIn/memoryWriteEnabledIn/aluResultIn/valRmIn/destinationIn : EX/MEM
//   mem      : data-memory bus (master side)
//   freeze   : stall IF/ID/EX and the EX/MEM register
//   writebackEnabled/memoryReadEnabled/aluResult/memoryData/destination : MEM/WB register
//
// state   | meaning
// IDLE    | no access outstanding; an access request is issued combinationally
// WAIT    | request held, waiting for memAck
// DONE    | access complete, result loads into MEM/WB, EX/MEM advances
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DATA_BASE  = DATA_BASE_DEFAULT,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 writebackEnabledIn,
    input  logic                 memoryReadEnabledIn,
    input  logic                 memoryWriteEnabledIn,
    input  logic [31:0]          aluResultIn,
    input  logic [31:0]          valRmIn,
    input  logic [3:0]           destinationIn,
    memory_stage_if.master       mem,
    output logic                 freeze,
    output logic                 writebackEnabled,
    output logic                 memoryReadEnabled,
    output logic [31:0]          aluResult,
    output logic [31:0]          memoryData,
    output logic [3:0]           destination
);
    state_e                state_q, state_d;
    logic                  access;
    logic                  issue;
    logic                  waiting;
    logic [31:0]           offs;
    logic [MEM_ADDR_W-1:0] addr_xl;
    logic                  unused_offs_bits;
    logic [MEM_ADDR_W-1:0] addr_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  is_load;
    logic [WB_REG_W-1:0]   wb_d, wb_q;

    assign access  = memoryReadEnabledIn | memoryWriteEnabledIn;
    assign is_load = memoryReadEnabledIn & ~memoryWriteEnabledIn;

    // Byte offset into the data segment; word address wraps at MEM_ADDR_W bits.
    assign offs             = aluResultIn - 32'(DATA_BASE);
    assign addr_xl          = offs[MEM_ADDR_W+1:2];
    assign unused_offs_bits = ^{offs[31:MEM_ADDR_W+2], offs[1:0]};

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        waiting = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by rst so an asserted reset drops memReq even if EX/MEM still shows an access.
                if (access && rst) begin
                    issue   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                waiting = 1'b1;
                if (mem.memAck) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                addr_q  <= addr_xl;
                we_q    <= memoryWriteEnabledIn;
                wdata_q <= valRmIn;
            end
            if (waiting && mem.memAck) begin
                rdata_q <= mem.memRdata;
            end
        end
    end

    // The request goes out in the IDLE decision cycle straight from EX/MEM, then from the held copy.
    assign mem.memReq   = issue | waiting;
    assign mem.memAddr  = issue ? addr_xl : addr_q;
    assign mem.memWe    = issue ? memoryWriteEnabledIn : we_q;
    assign mem.memWdata = issue ? valRmIn : wdata_q;
    assign freeze       = issue | waiting;

    always_comb begin
        wb_d = {writebackEnabledIn, memoryReadEnabledIn, aluResultIn,
                (is_load ? rdata_q : 32'h0), destinationIn};
        if (freeze) begin
            wb_d = {2'b00, wb_q[WB_REG_W-3:0]};
        end
    end

    memory_stage_reg #(.WIDTH(WB_REG_W)) u_mem_wb (
        .clk  (clk),
        .rst  (rst),
        .ld_i (1'b1),
        .d_i  (wb_d),
        .q_o  (wb_q)
    );

    assign writebackEnabled  = wb_q[69];
    assign memoryReadEnabled = wb_q[68];
    assign aluResult         = wb_q[67:36];
    assign memoryData        = wb_q[35:4];
    assign destination       = wb_q[3:0];
endmodule
